// File: rtl/load_unit.sv
// Load unit for the MEM stage: takes one load from the pipeline and issues a
// word-aligned read on the request/grant/rvalid data-memory interface. It then
// extracts and extends the byte, half or word from the response and returns it
// with a one-cycle writeback strobe. Misaligned loads are trapped without
// touching the bus.
module load_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_valid_i,
    input  logic [XLEN-1:0] load_addr_i,
    input  logic [2:0]      load_size_onehot_i,
    input  logic            load_unsigned_i,
    input  logic [4:0]      load_rd_i,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    output logic            busy_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic            misaligned_load_o,
    output logic            load_fault_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, EXC} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e          state_q;
    size_e           size_q;
    logic [XLEN-1:0] addr_q;
    logic            uns_q;
    logic [4:0]      rd_q;
    logic            cancel_q;
    logic            err_q;
    logic [XLEN-1:0] wb_data_q;
    logic [4:0]      wb_rd_q;

    size_e           size_d;
    logic            size_ok_d;
    logic            misaligned_d;
    logic [XLEN-1:0] fmt_data_d;
    logic [4:0]      byte_shift;
    logic [4:0]      half_shift;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;

    // Decode the request size with byte > half > word priority and check alignment
    always_comb begin
        size_d       = SZ_BYTE;
        size_ok_d    = 1'b1;
        misaligned_d = 1'b0;
        if (load_size_onehot_i[0]) begin
            size_d = SZ_BYTE;
        end else if (load_size_onehot_i[1]) begin
            size_d       = SZ_HALF;
            misaligned_d = load_addr_i[0];
        end else if (load_size_onehot_i[2]) begin
            size_d       = SZ_WORD;
            misaligned_d = |load_addr_i[1:0];
        end else begin
            size_ok_d = 1'b0;
        end
    end

    assign byte_shift = {addr_q[1:0], 3'b000};
    assign half_shift = {addr_q[1], 4'b0000};
    assign byte_val   = mem_rdata_i[byte_shift +: 8];
    assign half_val   = mem_rdata_i[half_shift +: 16];

    // Select the addressed lane of the response word and sign/zero-extend it
    always_comb begin
        fmt_data_d = mem_rdata_i;
        case (size_q)
            SZ_BYTE: fmt_data_d = {{(XLEN-8){~uns_q & byte_val[7]}}, byte_val};
            SZ_HALF: fmt_data_d = {{(XLEN-16){~uns_q & half_val[15]}}, half_val};
            default: fmt_data_d = mem_rdata_i;
        endcase
    end

    // Load sequencer: accept, request, wait for data, then pulse writeback or exception
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            size_q    <= SZ_BYTE;
            addr_q    <= '0;
            uns_q     <= 1'b0;
            rd_q      <= '0;
            cancel_q  <= 1'b0;
            err_q     <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cancel_q <= 1'b0;
                    if (load_valid_i && size_ok_d) begin
                        addr_q  <= load_addr_i;
                        size_q  <= size_d;
                        uns_q   <= load_unsigned_i;
                        rd_q    <= load_rd_i;
                        state_q <= misaligned_d ? EXC : REQ;
                    end
                end
                EXC: begin
                    state_q <= IDLE;
                end
                REQ: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (mem_gnt_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        err_q <= mem_err_i;
                        // A faulting response must not disturb the last good result
                        if (!mem_err_i) begin
                            wb_data_q <= fmt_data_d;
                            wb_rd_q   <= rd_q;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    cancel_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs derive from registered state; a flush arriving in RESP still cancels the pulses
    assign busy_o            = (state_q != IDLE);
    assign mem_req_o         = (state_q == REQ);
    assign mem_addr_o        = {addr_q[XLEN-1:2], 2'b00};
    assign misaligned_load_o = (state_q == EXC);
    assign wb_valid_o        = (state_q == RESP) && !err_q && !cancel_q && !flush_i;
    assign load_fault_o      = (state_q == RESP) && err_q && !cancel_q && !flush_i;
    assign wb_data_o         = wb_data_q;
    assign wb_rd_o           = wb_rd_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized loads
// compared against an arithmetic reference of the load formatting rules.
module tb_load_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        load_valid_i = 1'b0;
    logic [31:0] load_addr_i = '0;
    logic [2:0]  load_size_onehot_i = '0;
    logic        load_unsigned_i = 1'b0;
    logic [4:0]  load_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        busy_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        misaligned_load_o;
    logic        load_fault_o;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    // results of the most recent run_load
    int          r_busy, r_req, r_wb, r_wbcyc, r_fault, r_mis, r_addrbad, r_wbabs;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    bit          r_to;

    load_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .load_valid_i(load_valid_i), .load_addr_i(load_addr_i),
        .load_size_onehot_i(load_size_onehot_i), .load_unsigned_i(load_unsigned_i),
        .load_rd_i(load_rd_i), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .misaligned_load_o(misaligned_load_o), .load_fault_o(load_fault_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    function automatic int eff_bytes(input logic [2:0] size);
        if (size[0]) return 1;
        if (size[1]) return 2;
        if (size[2]) return 4;
        return 0;
    endfunction

    // Reference formatting: pick nbytes at the addressed offset, then extend
    function automatic logic [31:0] ref_format(input logic [31:0] addr, input int nbytes,
                                               input bit uns, input logic [31:0] rdata);
        longint unsigned word, span, v;
        int off;
        word = rdata;
        span = 64'd1 << (8 * nbytes);
        if (nbytes == 1) off = int'(addr % 4);
        else if (nbytes == 2) off = int'((addr % 4) / 2) * 2;
        else off = 0;
        v = (word >> (8 * off)) % span;
        if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // Drive one load and act as the memory; records what the DUT did each cycle
    task automatic run_load(input logic [31:0] addr, input logic [2:0] size, input bit uns,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input bit err, input int flush_cyc);
        int req_seen, gnt_cyc;
        bit done;
        req_seen = 0; gnt_cyc = -1; done = 0;
        r_busy = 0; r_req = 0; r_wb = 0; r_wbcyc = -1; r_fault = 0; r_mis = 0;
        r_addrbad = 0; r_wbabs = -1; r_data = 'x; r_rd = 'x;
        load_valid_i = 1'b1; load_addr_i = addr; load_size_onehot_i = size;
        load_unsigned_i = uns; load_rd_i = rd;
        @(posedge clk_i); #1;
        load_valid_i = 1'b0; load_addr_i = $urandom; load_size_onehot_i = 3'($urandom);
        load_unsigned_i = 1'($urandom); load_rd_i = 5'($urandom);
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
            mem_rdata_i = $urandom; flush_i = (cyc == flush_cyc);
            if (mem_req_o) begin
                if (req_seen == gnt_dly) begin mem_gnt_i = 1'b1; gnt_cyc = cyc; end
                req_seen++;
            end
            if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 + rv_dly) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
            end
            #1;
            if (!busy_o) done = 1;
            else r_busy++;
            if (mem_req_o) begin
                r_req++;
                if (mem_addr_o !== (addr & 32'hFFFF_FFFC)) r_addrbad++;
            end
            if (wb_valid_o) begin
                r_wb++; r_wbcyc = cyc; r_wbabs = cyc_cnt; r_data = wb_data_o; r_rd = wb_rd_o;
            end
            if (load_fault_o) r_fault++;
            if (misaligned_load_o) r_mis++;
            if (!done) begin @(posedge clk_i); #1; end
        end
        r_to = !done;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; flush_i = 1'b0;
        $display("[TB] load addr=%h size=%b uns=%0d rd=%0d busy=%0d req=%0d wb=%0d data=%h fault=%0d mis=%0d",
                 addr, size, uns, rd, r_busy, r_req, r_wb, r_data, r_fault, r_mis);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tests++;
        if ({busy_o, mem_req_o, wb_valid_o, misaligned_load_o, load_fault_o,
             mem_addr_o, wb_data_o, wb_rd_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b req=%b wbv=%b mis=%b flt=%b addr=%h data=%h rd=%0d, all required 0",
                     busy_o, mem_req_o, wb_valid_o, misaligned_load_o, load_fault_o,
                     mem_addr_o, wb_data_o, wb_rd_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_lb();
        run_load(32'h1003, 3'b001, 0, 5'd7, 0, 0, 32'h80FF_1234, 0, -1);
        tests++;
        if (r_wb !== 1 || r_data !== 32'hFFFF_FF80 || r_rd !== 5'd7) begin
            fails++;
            $display("FAIL lb_data: wb=%0d data=%h rd=%0d, required wb=1 data=ffffff80 rd=7", r_wb, r_data, r_rd);
        end
        tests++;
        if (r_wbcyc !== 3 || r_busy !== 3) begin
            fails++;
            $display("FAIL lb_latency: wb_cycle=%0d busy_cycles=%0d, required 3 and 3", r_wbcyc, r_busy);
        end
        tests++;
        if (r_req !== 1 || r_addrbad !== 0 || r_to) begin
            fails++;
            $display("FAIL lb_request: req_cycles=%0d bad_addr=%0d timeout=%0d, required 1 0 0", r_req, r_addrbad, r_to);
        end
    endtask

    task automatic test_half();
        run_load(32'h2002, 3'b010, 1, 5'd3, 0, 0, 32'h8001_7FFF, 0, -1);
        tests++;
        if (r_wb !== 1 || r_data !== 32'h0000_8001) begin
            fails++;
            $display("FAIL lhu_data: wb=%0d data=%h, required wb=1 data=00008001", r_wb, r_data);
        end
        run_load(32'h2002, 3'b010, 0, 5'd4, 0, 0, 32'h8001_7FFF, 0, -1);
        tests++;
        if (r_wb !== 1 || r_data !== 32'hFFFF_8001 || r_rd !== 5'd4) begin
            fails++;
            $display("FAIL lh_data: wb=%0d data=%h rd=%0d, required wb=1 data=ffff8001 rd=4", r_wb, r_data, r_rd);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0] sizes [2];
        sizes[0] = 3'b100; sizes[1] = 3'b010;
        for (int i = 0; i < 2; i++) begin
            run_load(32'h3001, sizes[i], 0, 5'd9, 0, 0, 32'h1111_2222, 0, -1);
            tests++;
            if (r_mis !== 1 || r_req !== 0 || r_wb !== 0 || r_busy !== 1 || r_fault !== 0) begin
                fails++;
                $display("FAIL misaligned_%b: mis=%0d req=%0d wb=%0d busy=%0d fault=%0d, required 1 0 0 1 0",
                         sizes[i], r_mis, r_req, r_wb, r_busy, r_fault);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        run_load(32'h4000, 3'b100, 1, 5'd12, 3, 1, d, 0, -1);
        tests++;
        if (r_req !== 4 || r_addrbad !== 0) begin
            fails++;
            $display("FAIL stall_request: req_cycles=%0d bad_addr=%0d, required 4 and 0", r_req, r_addrbad);
        end
        tests++;
        if (r_wb !== 1 || r_data !== d || r_wbcyc !== 7 || r_busy !== 7) begin
            fails++;
            $display("FAIL stall_wb: wb=%0d data=%h cycle=%0d busy=%0d, required 1 %h 7 7", r_wb, r_data, r_wbcyc, r_busy, d);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        d = $urandom;
        run_load(32'h5004, 3'b100, 0, 5'd5, 0, 2, d, 0, 3);
        tests++;
        if (r_wb !== 0 || r_fault !== 0 || r_busy !== 5 || r_req !== 1) begin
            fails++;
            $display("FAIL flush_wait: wb=%0d fault=%0d busy=%0d req=%0d, required 0 0 5 1", r_wb, r_fault, r_busy, r_req);
        end
        run_load(32'h5008, 3'b100, 0, 5'd6, 0, 0, ~d, 0, -1);
        tests++;
        if (r_wb !== 1 || r_data !== ~d || r_rd !== 5'd6) begin
            fails++;
            $display("FAIL flush_next: wb=%0d data=%h rd=%0d, required 1 %h 6", r_wb, r_data, r_rd, ~d);
        end
    endtask

    task automatic test_error();
        run_load(32'h6001, 3'b001, 1, 5'd21, 0, 0, 32'h0000_AB00, 0, -1);
        run_load(32'h6004, 3'b100, 0, 5'd22, 1, 0, 32'hDEAD_BEEF, 1, -1);
        tests++;
        if (r_fault !== 1 || r_wb !== 0 || r_busy !== 4) begin
            fails++;
            $display("FAIL error_pulse: fault=%0d wb=%0d busy=%0d, required 1 0 4", r_fault, r_wb, r_busy);
        end
        tests++;
        if (wb_data_o !== 32'h0000_00AB || wb_rd_o !== 5'd21) begin
            fails++;
            $display("FAIL error_hold: data=%h rd=%0d, required 000000ab 21", wb_data_o, wb_rd_o);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        load_valid_i = 1'b1; load_addr_i = 32'h7000; load_size_onehot_i = 3'b100; load_rd_i = 5'd30;
        @(posedge clk_i); #1;
        load_valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0; rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = (i == 0); mem_rdata_i = $urandom;
            #1;
            if ({busy_o, mem_req_o, wb_valid_o, misaligned_load_o, load_fault_o,
                 mem_addr_o, wb_data_o, wb_rd_o} !== '0) bad++;
            @(posedge clk_i); #1;
        end
        mem_rvalid_i = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_mid: cycles with nonzero outputs=%0d, required 0", bad);
        end
    endtask

    task automatic test_noop();
        run_load(32'h8000, 3'b000, 0, 5'd1, 0, 0, 32'h1234_5678, 0, -1);
        tests++;
        if (r_busy !== 0 || r_req !== 0 || r_wb !== 0 || r_mis !== 0) begin
            fails++;
            $display("FAIL noop: busy=%0d req=%0d wb=%0d mis=%0d, required all 0", r_busy, r_req, r_wb, r_mis);
        end
    endtask

    task automatic test_back_to_back();
        int first_abs;
        run_load(32'h9001, 3'b001, 1, 5'd10, 0, 0, 32'h0000_5A00, 0, -1);
        first_abs = r_wbabs;
        run_load(32'h9002, 3'b010, 0, 5'd11, 0, 0, 32'hC3C3_0000, 0, -1);
        tests++;
        if (r_wbabs - first_abs !== 4 || r_data !== 32'hFFFF_C3C3 || r_rd !== 5'd11) begin
            fails++;
            $display("FAIL back_to_back: spacing=%0d data=%h rd=%0d, required 4 ffffc3c3 11",
                     r_wbabs - first_abs, r_data, r_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] known_data, addr, d;
        logic [4:0]  known_rd, rd;
        logic [2:0]  size;
        bit          known, uns, err, flushed;
        int          nb, gd, rv, fc, exp_busy;
        known = 0; known_data = '0; known_rd = '0;
        for (int it = 0; it < 40; it++) begin
            addr = $urandom; size = 3'($urandom_range(0, 7)); uns = 1'($urandom);
            rd = 5'($urandom); d = $urandom; err = ($urandom_range(0, 7) == 0);
            gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
            nb = eff_bytes(size);
            exp_busy = (nb == 0) ? 0 : (addr % nb != 0) ? 1 : gd + rv + 3;
            fc = ($urandom_range(0, 5) == 0 && exp_busy > 0) ? $urandom_range(1, exp_busy) : -1;
            flushed = (fc > 0) && (exp_busy > 1);
            run_load(addr, size, uns, rd, gd, rv, d, err, fc);
            tests++;
            if (r_busy !== exp_busy || r_to || r_addrbad !== 0) begin
                fails++;
                $display("FAIL rand_busy[%0d]: busy=%0d timeout=%0d bad_addr=%0d, required %0d 0 0",
                         it, r_busy, r_to, r_addrbad, exp_busy);
            end
            tests++;
            if (r_mis !== int'(exp_busy == 1) || r_req !== ((exp_busy > 1) ? gd + 1 : 0)) begin
                fails++;
                $display("FAIL rand_mis_req[%0d]: mis=%0d req=%0d, required %0d %0d",
                         it, r_mis, r_req, int'(exp_busy == 1), (exp_busy > 1) ? gd + 1 : 0);
            end
            tests++;
            if (r_wb !== int'(exp_busy > 1 && !flushed && !err) ||
                r_fault !== int'(exp_busy > 1 && !flushed && err)) begin
                fails++;
                $display("FAIL rand_pulses[%0d]: wb=%0d fault=%0d, required %0d %0d", it, r_wb, r_fault,
                         int'(exp_busy > 1 && !flushed && !err), int'(exp_busy > 1 && !flushed && err));
            end
            if (exp_busy > 1 && !err) begin
                if (flushed) begin
                    known = 0;
                end else begin
                    known = 1; known_data = ref_format(addr, nb, uns, d); known_rd = rd;
                end
            end
            if (known) begin
                tests++;
                if (wb_data_o !== known_data || wb_rd_o !== known_rd) begin
                    fails++;
                    $display("FAIL rand_data[%0d]: data=%h rd=%0d, required %h %0d",
                             it, wb_data_o, wb_rd_o, known_data, known_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_half();
        test_misaligned();
        test_stall();
        test_flush();
        test_error();
        test_noop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart of the store formatting path in the MEM stage.
- Accepts one load from the pipeline and issues a word-aligned read on the data-memory request/grant/rvalid interface.
- Waits for the response, then extracts the byte, half or word and sign- or zero-extends it.
- Presents a one-cycle writeback pulse and raises busy_o to stall the pipeline while a load is outstanding; misaligned loads are trapped without any memory access.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- load_valid_i  in  1  load request from the MEM stage; sampled only when busy_o=0
- load_addr_i  in  32  effective byte address
- load_size_onehot_i  in  3  [0]=byte, [1]=half, [2]=word
- load_unsigned_i  in  1  1 = zero-extend (LBU/LHU)
- load_rd_i  in  5  destination register tag
- flush_i  in  1  cancel writeback of the in-flight load
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data word
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- busy_o  out  1  load outstanding; pipeline must stall
- wb_valid_o  out  1  one-cycle writeback strobe
- wb_data_o  out  32  formatted load result
- wb_rd_o  out  5  destination tag for wb_data_o
- misaligned_load_o  out  1  one-cycle exception pulse
- load_fault_o  out  1  one-cycle access-fault pulse

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including mem_addr_o, wb_data_o and wb_rd_o.
  - Reset mid-operation abandons the transaction; a later stray mem_rvalid_i in IDLE is ignored.
- Misalignment check on acceptance:
  - Byte: never misaligned.
  - Half: misaligned when addr[0]=1.
  - Word: misaligned when addr[1:0]!=0.
  - size_onehot=000: no operation, no state change.
  - More than one bit set: priority is byte > half > word.
- State IDLE:
  - busy_o=0.
  - load_valid_i with a valid size: register addr, size, unsigned and rd.
  - If misaligned: go to EXC.
  - Else: go to REQ.
- State EXC:
  - misaligned_load_o=1 and busy_o=1 for exactly one cycle, then IDLE.
  - No memory request is issued and wb_valid_o stays 0.
- State REQ:
  - mem_req_o=1 and mem_addr_o valid; both held stable until mem_gnt_i.
  - On gnt: go to WAIT.
  - Earliest request cycle is the cycle after acceptance.
- State WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, capture formatted data and go to RESP.
  - mem_rvalid_i is never asserted in the same cycle as its gnt, so the earliest response is gnt cycle +1.
- State RESP (one cycle, then IDLE):
  - If no error and not flushed: wb_valid_o=1.
  - If mem_err_i was set: load_fault_o=1 and wb_valid_o=0.
  - If flushed: both pulses suppressed.
- busy_o:
  - Equals 1 in REQ, WAIT, EXC and RESP.
  - Next load is accepted the cycle after RESP/EXC, so minimum load-to-load spacing is 4 cycles.
- Flush:
  - flush_i in REQ/WAIT/RESP sets a sticky cancel flag; it is also sampled in the RESP cycle itself.
  - A flushed load still completes its bus handshake and consumes its response, so the bus is never abandoned.
  - The cancel flag clears on return to IDLE.
  - flush_i in IDLE or EXC has no effect.
- Formatting (registered at rvalid):
  - Byte: sh = addr[1:0]*8; b = rdata[sh+7:sh]; extend b[7] unless unsigned.
  - Half: sh = addr[1]*16; h = rdata[sh+15:sh]; extend h[15] unless unsigned.
  - Word: rdata unchanged; load_unsigned_i ignored.
- Holding values:
  - wb_data_o and wb_rd_o hold their last value outside RESP.
  - Only wb_valid_o qualifies them.
  - An error response leaves wb_data_o unchanged.
- Latency with a zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle): acceptance at cycle 0 gives wb_valid_o at cycle 3.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234, zero-wait -> mem_addr_o=0x1000; wb_data_o=0xFFFF_FF80 at cycle 3; busy_o high cycles 1-3.
- LHU addr=0x2002, rdata=0x8001_7FFF -> wb_data_o=0x0000_8001. Repeat as LH -> 0xFFFF_8001.
- LW addr=0x3001 -> misaligned_load_o single pulse, mem_req_o never asserted, wb_valid_o=0. LH addr=0x3001 -> same result.
- LW addr=0x4000, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_req_o/mem_addr_o stable through the stall; single wb_valid_o with data=rdata.
- flush_i pulsed during WAIT -> handshake completes, wb_valid_o=0; next load accepted normally and written back.
- Response with mem_err_i=1 -> load_fault_o pulse, no wb_valid_o. Separately, rst_ni=0 during WAIT followed by a late rvalid -> all outputs 0, no writeback, state stays IDLE.
